// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer stream block.
package fc_pkg;

  // Pass sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMac,
    StBias,
    StEmit
  } fc_state_e;

  localparam int unsigned DefNumIn  = 5;
  localparam int unsigned DefNumOut = 3;
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefFracW  = 8;
  localparam int unsigned DefAccW   = 40;

  // Clamp a signed value into the range of a signed word of the given width.
  function automatic logic signed [63:0] fc_saturate(input logic signed [63:0] val,
                                                     input int unsigned      width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end
    return val;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate datapath: clear, accumulate products, add bias, rescale and saturate.
// Optional feature: FC_LAYER_STREAM_RELU_EN clamps negative results to zero.
module fc_mac
  import fc_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned FRAC_W = DefFracW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              mac_en_i,
  input  logic              bias_en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [DATA_W-1:0]   res_q, res_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    bias_sum;
  logic signed [ACC_W-1:0]    scaled;
  logic signed [63:0]         sat;

  // Product, bias alignment and final rescale/saturation of the running sum.
  always_comb begin
    // Operands sign-extended first so the product keeps full signed precision.
    prod     = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    prod_ext = $signed({{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod});
    bias_ext = $signed({{(ACC_W - DATA_W){b_i[DATA_W-1]}}, b_i}) <<< FRAC_W;
    bias_sum = acc_q + bias_ext;
    scaled   = bias_sum >>> FRAC_W;
    sat      = fc_saturate($signed({{(64 - ACC_W){scaled[ACC_W-1]}}, scaled}), DATA_W);
`ifdef FC_LAYER_STREAM_RELU_EN
    res_d = sat[DATA_W-1] ? '0 : sat[DATA_W-1:0];
`else
    res_d = sat[DATA_W-1:0];
`endif
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + prod_ext;
    end else if (bias_en_i) begin
      acc_d = bias_sum;
    end
  end

  // Accumulator and registered output word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (bias_en_i) begin
        res_q <= res_d;
      end
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: buffers NUM_IN inputs, then per output row
// accumulates NUM_IN weighted inputs plus a bias and emits one word.
// Optional feature: FC_LAYER_STREAM_RELU_EN (ReLU on each output, see fc_mac).
module fc_layer_stream
  import fc_pkg::*;
#(
  parameter int unsigned NUM_IN  = DefNumIn,
  parameter int unsigned NUM_OUT = DefNumOut,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned FRAC_W  = DefFracW,
  parameter int unsigned ACC_W   = DefAccW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              w_valid_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              finished_o
);

  localparam int unsigned InIdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned RowW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [InIdxW-1:0] InLast  = InIdxW'(NUM_IN - 1);
  localparam logic [RowW-1:0]   RowLast = RowW'(NUM_OUT - 1);

  fc_state_e         state_q, state_d;
  logic [InIdxW-1:0] in_cnt_q, in_cnt_d;
  logic [InIdxW-1:0] w_cnt_q, w_cnt_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              fin_q, fin_d;
  logic [DATA_W-1:0] in_buf_q [NUM_IN];
  logic              mac_clear, mac_en, bias_en;
  logic              in_ready, w_ready, out_valid;

  // Next-state, counters and handshake decode.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    w_cnt_d   = w_cnt_q;
    row_d     = row_q;
    fin_d     = 1'b0;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    bias_en   = 1'b0;
    in_ready  = 1'b0;
    w_ready   = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StLoad;
          in_cnt_d = '0;
          w_cnt_d  = '0;
          row_d    = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          if (in_cnt_q == InLast) begin
            state_d   = StMac;
            in_cnt_d  = '0;
            mac_clear = 1'b1;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      StMac: begin
        w_ready = 1'b1;
        if (w_valid_i) begin
          mac_en = 1'b1;
          if (w_cnt_q == InLast) begin
            state_d = StBias;
            w_cnt_d = '0;
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      StBias: begin
        w_ready = 1'b1;
        if (w_valid_i) begin
          bias_en = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready_i) begin
          if (row_q == RowLast) begin
            state_d = StIdle;
            row_d   = '0;
            fin_d   = 1'b1;
          end else begin
            state_d   = StMac;
            row_d     = row_q + 1'b1;
            mac_clear = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      in_cnt_q <= '0;
      w_cnt_q  <= '0;
      row_q    <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      w_cnt_q  <= w_cnt_d;
      row_q    <= row_d;
      fin_q    <= fin_d;
    end
  end

  // Input-node buffer, written in order during LOAD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_IN; k++) begin
        in_buf_q[k] <= '0;
      end
    end else if (in_ready && in_valid_i) begin
      in_buf_q[in_cnt_q] <= in_data_i;
    end
  end

  fc_mac #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (mac_clear),
    .mac_en_i (mac_en),
    .bias_en_i(bias_en),
    .a_i      (in_buf_q[w_cnt_q]),
    .b_i      (w_data_i),
    .result_o (out_data_o)
  );

  assign in_ready_o  = in_ready;
  assign w_ready_o   = w_ready;
  assign out_valid_o = out_valid;
  assign busy_o      = (state_q != StIdle);
  assign finished_o  = fin_q;

endmodule
